freq_ramp_gen: RTL and testbench

- Downstream consumer of the 8-bit HMI frequency setpoint `freq`, in Hz.
- Slews the actual output frequency toward the setpoint at a bounded rate and integrates it into a 32-bit phase accumulator.
- Inputs: `clk_sys` and the 1 us strobe `pluse_us` from the clock/reset block.
- Outputs `phase` and `phase_wrap` feed the later waveform/PWM stage of the VFD datapath.

---
 rtl/freq_ramp_gen.sv | 216 +++++++++++++++++++++
 tb/tb_freq_ramp_gen.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_ramp_gen.sv
// freq_ramp_gen: slews the running frequency toward the HMI setpoint at a bounded rate and
// integrates it into a 32-bit phase accumulator for the waveform/PWM stage.
//
// Ports:
//   clk_sys    in   system clock
//   rst        in   synchronous, active-high reset
//   pluse_us   in   one-cycle strobe, once per microsecond
//   run        in   1 = drive enabled, 0 = ramp down to stop
//   freq[7:0]  in   frequency setpoint in Hz
//   dir        in   requested rotation direction (FREQ_RAMP_REV_EN builds only)
//   dir_act    out  applied rotation direction (FREQ_RAMP_REV_EN builds only)
//   freq_act   out  current slewed frequency in Hz
//   phase      out  phase accumulator; [31:24] indexes the sine table
//   phase_wrap out  one-cycle pulse after the accumulator wraps (or borrows in reverse)
//   state      out  0 = IDLE, 1 = ACCEL, 2 = RUN, 3 = DECEL
//   busy       out  high when state is not IDLE
//
// Optional feature: define FREQ_RAMP_REV_EN to add direction reversal through zero speed.
module freq_ramp_gen #(
    parameter int unsigned FREQ_MIN   = 5,
    parameter int unsigned FREQ_MAX   = 200,
    parameter int unsigned RAMP_US    = 10000,
    parameter int unsigned INC_PER_HZ = 4295
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        pluse_us,
    input  logic        run,
    input  logic [7:0]  freq,
`ifdef FREQ_RAMP_REV_EN
    input  logic        dir,
    output logic        dir_act,
`endif
    output logic [7:0]  freq_act,
    output logic [31:0] phase,
    output logic        phase_wrap,
    output logic [1:0]  state,
    output logic        busy
);

    localparam int unsigned CntW = (RAMP_US > 1) ? $clog2(RAMP_US) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(RAMP_US - 1);
    localparam logic [7:0] FMin = 8'(FREQ_MIN);
    localparam logic [7:0] FMax = 8'(FREQ_MAX);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccel = 2'd1,
        StRun   = 2'd2,
        StDecel = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      freq_act_q, freq_act_d;
    logic [31:0]     phase_q, phase_d;
    logic            phase_wrap_q, phase_wrap_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [7:0]  tgt_raw;
    logic [7:0]  tgt;
    logic        ramping;
    logic        tick;
    logic        restart;
    logic        clear_phase;
    logic [31:0] inc;
    logic [32:0] acc;

`ifdef FREQ_RAMP_REV_EN
    logic dir_act_q, dir_act_d;
    logic rev_pend;
`endif

    // Target frequency: zero when stopped, otherwise clamped into the running band.
    always_comb begin
        tgt_raw = 8'd0;
        if (run && (freq != 8'd0)) begin
            if (freq < FMin) begin
                tgt_raw = FMin;
            end else if (freq > FMax) begin
                tgt_raw = FMax;
            end else begin
                tgt_raw = freq;
            end
        end
        tgt = tgt_raw;
`ifdef FREQ_RAMP_REV_EN
        // A pending reversal must pass through zero speed first.
        rev_pend = (dir != dir_act_q) && (state_q != StIdle);
        if (rev_pend) begin
            tgt = 8'd0;
        end
`endif
    end

    assign ramping = (state_q == StAccel) || (state_q == StDecel);
    assign tick    = ramping && pluse_us && (cnt_q == CntLast);

    always_comb begin
        state_d     = state_q;
        freq_act_d  = freq_act_q;
        restart     = 1'b0;
        clear_phase = 1'b0;
`ifdef FREQ_RAMP_REV_EN
        dir_act_d   = dir_act_q;
`endif
        if (state_q == StIdle) begin
`ifdef FREQ_RAMP_REV_EN
            dir_act_d = dir;
`endif
            if (tgt != 8'd0) begin
                state_d = StAccel;
            end
        end else if ((freq_act_q == 8'd0) && (tgt == 8'd0)) begin
            // Standstill reached: either stop, or reverse and restart without idling.
`ifdef FREQ_RAMP_REV_EN
            if (rev_pend) begin
                dir_act_d = dir;
                if (tgt_raw != 8'd0) begin
                    state_d = StAccel;
                    restart = 1'b1;
                end else begin
                    state_d     = StIdle;
                    clear_phase = 1'b1;
                end
            end else begin
                state_d     = StIdle;
                clear_phase = 1'b1;
            end
`else
            state_d     = StIdle;
            clear_phase = 1'b1;
`endif
        end else if (freq_act_q == tgt) begin
            state_d = StRun;
        end else if (freq_act_q < tgt) begin
            if (state_q == StAccel) begin
                if (tick) begin
                    freq_act_d = (freq_act_q == 8'd0) ? FMin : freq_act_q + 8'd1;
                end
            end else begin
                state_d = StAccel;
            end
        end else begin
            if (state_q == StDecel) begin
                if (tick) begin
                    freq_act_d = (freq_act_q <= FMin) ? 8'd0 : freq_act_q - 8'd1;
                end
            end else begin
                state_d = StDecel;
            end
        end
    end

    // Ramp counter restarts on any state change so the first step is a full interval away.
    always_comb begin
        cnt_d = cnt_q;
        if (!ramping || (state_d != state_q) || restart) begin
            cnt_d = '0;
        end else if (pluse_us) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    // Phase integrates the pre-update frequency; bit 32 of the add is the wrap/borrow flag.
    assign inc = 32'(freq_act_q) * INC_PER_HZ;

    always_comb begin
`ifdef FREQ_RAMP_REV_EN
        acc = dir_act_q ? ({1'b0, phase_q} - {1'b0, inc}) : ({1'b0, phase_q} + {1'b0, inc});
`else
        acc = {1'b0, phase_q} + {1'b0, inc};
`endif
        phase_d      = phase_q;
        phase_wrap_d = 1'b0;
        if (pluse_us) begin
            phase_d      = acc[31:0];
            phase_wrap_d = acc[32];
        end
        if (clear_phase) begin
            phase_d      = 32'd0;
            phase_wrap_d = 1'b0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q      <= StIdle;
            freq_act_q   <= 8'd0;
            phase_q      <= 32'd0;
            phase_wrap_q <= 1'b0;
            cnt_q        <= '0;
`ifdef FREQ_RAMP_REV_EN
            dir_act_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            freq_act_q   <= freq_act_d;
            phase_q      <= phase_d;
            phase_wrap_q <= phase_wrap_d;
            cnt_q        <= cnt_d;
`ifdef FREQ_RAMP_REV_EN
            dir_act_q    <= dir_act_d;
`endif
        end
    end

    assign freq_act   = freq_act_q;
    assign phase      = phase_q;
    assign phase_wrap = phase_wrap_q;
    assign state      = state_q;
    assign busy       = (state_q != StIdle);
`ifdef FREQ_RAMP_REV_EN
    assign dir_act    = dir_act_q;
`endif

endmodule

// File: tb/tb_freq_ramp_gen.sv
// Testbench for freq_ramp_gen: table of setpoint steps, each expanded into a queue of expected
// (state, freq_act, microseconds-after-stimulus) events that a negedge monitor pops and compares.
module tb_freq_ramp_gen;

    localparam int unsigned RampUs = 4;
    localparam logic [31:0] Inc    = 32'd16777216;
    localparam logic [7:0]  FMin   = 8'd5;

    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic        pluse_us = 1'b0;
    logic        run = 1'b0;
    logic [7:0]  freq = 8'd0;
    logic [7:0]  freq_act;
    logic [31:0] phase;
    logic        phase_wrap;
    logic [1:0]  state;
    logic        busy;
`ifdef FREQ_RAMP_REV_EN
    logic        dir = 1'b0;
    logic        dir_act;
`endif

    freq_ramp_gen #(
        .FREQ_MIN  (5),
        .FREQ_MAX  (200),
        .RAMP_US   (RampUs),
        .INC_PER_HZ(Inc)
    ) dut (
        .clk_sys   (clk_sys),
        .rst       (rst),
        .pluse_us  (pluse_us),
        .run       (run),
        .freq      (freq),
`ifdef FREQ_RAMP_REV_EN
        .dir       (dir),
        .dir_act   (dir_act),
`endif
        .freq_act  (freq_act),
        .phase     (phase),
        .phase_wrap(phase_wrap),
        .state     (state),
        .busy      (busy)
    );

    always #5 clk_sys = ~clk_sys;

    // One-cycle strobe every 10 clocks.
    initial begin
        int pc;
        pc = 0;
        forever begin
            @(posedge clk_sys);
            #1;
            pc = (pc == 9) ? 0 : pc + 1;
            pluse_us = (pc == 0);
        end
    end

    typedef struct {
        logic [1:0] st;
        logic [7:0] fa;
        int         dly;
    } ev_t;

    typedef struct {
        logic       r;
        logic [7:0] f;
        logic [7:0] exp_fa;
        logic [1:0] exp_st;
        int         hold_us;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          pulse_cnt = 0;
    int          base = 0;
    int          wrap_cnt = 0;
    bit          mon_en = 1'b0;
    ev_t         sb[$];
    logic [1:0]  prev_st = 2'd0;
    logic [7:0]  prev_fa = 8'd0;
    logic [31:0] exp_phase = 32'd0;
    logic        wrap_pend = 1'b0;
    logic [32:0] sum;
    logic [7:0]  model_f = 8'd0;
    vec_t        vecs[9];

    // Monitor: event scoreboard, pulse counting and a reference phase accumulator.
    initial begin
        ev_t ev;
        forever begin
            @(negedge clk_sys);
            if (mon_en && !rst && ((state != prev_st) || (freq_act != prev_fa))) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: state=%0d freq_act=%0d at %0d us",
                             state, freq_act, pulse_cnt - base);
                end else begin
                    ev = sb.pop_front();
                    if ((ev.st != state) || (ev.fa != freq_act) || (ev.dly != pulse_cnt - base)) begin
                        errors++;
                        $display("FAIL event: got state=%0d freq_act=%0d at %0d us, want state=%0d freq_act=%0d at %0d us",
                                 state, freq_act, pulse_cnt - base, ev.st, ev.fa, ev.dly);
                    end
                end
            end
            prev_st = state;
            prev_fa = freq_act;
            if (rst) begin
                exp_phase = 32'd0;
                wrap_pend = 1'b0;
            end else begin
                if (state == 2'd0) exp_phase = 32'd0;
                if (wrap_pend || phase_wrap) begin
                    checks++;
                    if (phase_wrap !== wrap_pend) begin
                        errors++;
                        $display("FAIL phase_wrap: got %0b want %0b", phase_wrap, wrap_pend);
                    end
                end
                if (phase_wrap) wrap_cnt++;
                wrap_pend = 1'b0;
                if (pluse_us) begin
                    pulse_cnt++;
                    sum = {1'b0, exp_phase} + {1'b0, 32'(freq_act) * Inc};
                    exp_phase = sum[31:0];
                    wrap_pend = sum[32];
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Return two time units after a posedge that consumed a strobe.
    task automatic sync_pulse();
        do begin
            @(posedge clk_sys);
        end while (pluse_us !== 1'b1);
        #2;
    endtask

    // Drive a new setpoint and queue the ramp the block should produce toward t.
    task automatic apply(input logic r, input logic [7:0] f, input logic [7:0] t);
        logic [7:0] cur;
        int k;
        sync_pulse();
        cur = model_f;
        k = 0;
        if (t > cur) begin
            sb.push_back('{2'd1, cur, 0});
            while (cur < t) begin
                cur = (cur == 8'd0) ? FMin : cur + 8'd1;
                k++;
                sb.push_back('{2'd1, cur, k * RampUs});
            end
            sb.push_back('{2'd2, t, k * RampUs});
        end else if (t < cur) begin
            sb.push_back('{2'd3, cur, 0});
            while (cur > t) begin
                cur = (cur <= FMin) ? 8'd0 : cur - 8'd1;
                k++;
                sb.push_back('{2'd3, cur, k * RampUs});
            end
            sb.push_back('{(t == 8'd0) ? 2'd0 : 2'd2, t, k * RampUs});
        end
        model_f = t;
        base = pulse_cnt;
        run = r;
        freq = f;
    endtask

    task automatic wait_settle(input int budget_clk);
        int n;
        n = 0;
        while ((sb.size() != 0) && (n < budget_clk)) begin
            @(posedge clk_sys);
            n++;
        end
        #3;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d pending events want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_rest(input string tag, input logic [7:0] fa, input logic [1:0] st);
        chk({tag, ".freq_act"}, 32'(freq_act), 32'(fa));
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".busy"}, 32'(busy), (st != 2'd0) ? 32'd1 : 32'd0);
        chk({tag, ".phase"}, phase, exp_phase);
    endtask

    initial begin
        int w0;
        vecs[0] = '{1'b0, 8'd50,  8'd0,   2'd0, 100};
        vecs[1] = '{1'b1, 8'd10,  8'd10,  2'd2, 8};
        vecs[2] = '{1'b1, 8'd8,   8'd8,   2'd2, 8};
        vecs[3] = '{1'b0, 8'd8,   8'd0,   2'd0, 8};
        vecs[4] = '{1'b1, 8'd0,   8'd0,   2'd0, 20};
        vecs[5] = '{1'b1, 8'd5,   8'd5,   2'd2, 8};
        vecs[6] = '{1'b1, 8'd255, 8'd200, 2'd2, 8};
        vecs[7] = '{1'b1, 8'd2,   8'd5,   2'd2, 8};
        vecs[8] = '{1'b1, 8'd16,  8'd16,  2'd2, 8};

        // Reset held for three clocks.
        repeat (3) @(posedge clk_sys);
        #3;
        chk("rst.freq_act", 32'(freq_act), 32'd0);
        chk("rst.phase", phase, 32'd0);
        chk("rst.phase_wrap", 32'(phase_wrap), 32'd0);
        chk("rst.state", 32'(state), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
`ifdef FREQ_RAMP_REV_EN
        chk("rst.dir_act", 32'(dir_act), 32'd0);
`endif
        rst = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 9; i++) begin
            int diff;
            diff = (vecs[i].exp_fa > model_f) ? int'(vecs[i].exp_fa) - int'(model_f)
                                              : int'(model_f) - int'(vecs[i].exp_fa);
            apply(vecs[i].r, vecs[i].f, vecs[i].exp_fa);
            wait_settle((diff + 4) * RampUs * 10 + 50);
            repeat (vecs[i].hold_us * 10) @(posedge clk_sys);
            #3;
            check_rest($sformatf("vec%0d", i), vecs[i].exp_fa, vecs[i].exp_st);
        end

        // Running at 16 Hz with 2^24 per Hz: one wrap every 16 strobes.
        sync_pulse();
        @(negedge clk_sys);
        w0 = wrap_cnt;
        repeat (640) @(posedge clk_sys);
        @(posedge clk_sys);
        #3;
        chk("wrap_count_64us", 32'(wrap_cnt - w0), 32'd4);
        chk("wrap.phase", phase, exp_phase);

        // Stop from 16 Hz: steps down to FREQ_MIN, then straight to zero with phase cleared.
        apply(1'b0, 8'd16, 8'd0);
        wait_settle(30 * RampUs * 10);
        repeat (20) @(posedge clk_sys);
        #3;
        check_rest("stop", 8'd0, 2'd0);
        chk("stop.phase_zero", phase, 32'd0);

        // Reset in the middle of a ramp aborts at once.
        sync_pulse();
        mon_en = 1'b0;
        sb.delete();
        run = 1'b1;
        freq = 8'd20;
        repeat (100) @(posedge clk_sys);
        #3;
        chk("midramp.freq_act", 32'(freq_act), 32'd6);
        chk("midramp.state", 32'(state), 32'd1);
        chk("midramp.busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk_sys);
        #3;
        chk("midrst.freq_act", 32'(freq_act), 32'd0);
        chk("midrst.phase", phase, 32'd0);
        chk("midrst.phase_wrap", 32'(phase_wrap), 32'd0);
        chk("midrst.state", 32'(state), 32'd0);
        chk("midrst.busy", 32'(busy), 32'd0);
        run = 1'b0;
        rst = 1'b0;
        model_f = 8'd0;
        repeat (30) @(posedge clk_sys);
        #3;
        chk("post_rst.state", 32'(state), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
